instruction_fetch_unit: RTL and testbench

- Initiator side of the instruction-memory interface.
- Owns the program counter and drives the word address into the combinational instruction memory (10-bit word index, 32-bit instruction returned in the same cycle).
- Captures the returned instruction into the IF/ID pipeline register.
- Handles sequential fetch, branch/jump redirect, stall and flush; sits between the instruction memory and the decode stage of the MIPS datapath.

---
 rtl/instruction_fetch_unit_if.sv | 8 +
 rtl/instruction_fetch_unit.sv | 99 +++++++++
 tb/tb_instruction_fetch_unit.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_unit_if.sv
// rtl/instruction_fetch_unit_if.sv - instruction-memory bus between fetch unit (master) and memory (slave)
interface instruction_fetch_unit_if;
    logic [9:0]  IMemAddress;
    logic [31:0] IMemInstruction;

    modport master (output IMemAddress, input IMemInstruction);
    modport slave  (input IMemAddress, output IMemInstruction);
endinterface

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - PC, instruction fetch and IF/ID register; optional IMEM_BOUND_CHECK_EN range check
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_DEPTH = 397
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Stall,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    input  logic        Jump,
    input  logic [31:0] JumpTarget,
    instruction_fetch_unit_if.master imem,
    output logic [31:0] PC,
    output logic [31:0] IFID_Instruction,
    output logic [31:0] IFID_PCPlus4,
    output logic        IFID_Valid,
    output logic [31:0] FetchCount,
    output logic        FetchFault
);
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pcp4_q, pcp4_d;
    logic [31:0] count_q, count_d;
    logic        valid_q, valid_d;
    logic        fault_q, fault_d;

    logic        redirect, capture, out_of_range;
    logic [31:0] pc_plus4, target;

    assign pc_plus4 = pc_q + 32'd4;
    assign redirect = Jump | BranchTaken;
    assign capture  = ~redirect & ~Stall;
    assign target   = Jump ? {JumpTarget[31:2], 2'b00} : {BranchTarget[31:2], 2'b00};

    assign imem.IMemAddress = pc_q[11:2];

`ifdef IMEM_BOUND_CHECK_EN
    localparam logic [10:0] DEPTH_W = 11'(IMEM_DEPTH);
    assign out_of_range = ({1'b0, pc_q[11:2]} >= DEPTH_W);
`else
    logic [10:0] unused_depth;
    assign unused_depth = 11'(IMEM_DEPTH);
    assign out_of_range = 1'b0;
`endif

    // Target low bits are discarded: fetches are always word aligned.
    logic [3:0] unused_tgt_bits;
    assign unused_tgt_bits = {BranchTarget[1:0], JumpTarget[1:0]};

    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        pcp4_d  = pcp4_q;
        valid_d = valid_q;
        count_d = count_q;
        fault_d = fault_q;
        if (redirect) begin
            pc_d    = target;
            instr_d = 32'h0;
            pcp4_d  = 32'h0;
            valid_d = 1'b0;
        end else if (capture) begin
            pc_d    = pc_plus4;
            instr_d = out_of_range ? 32'h0 : imem.IMemInstruction;
            pcp4_d  = pc_plus4;
            valid_d = ~out_of_range;
            fault_d = fault_q | out_of_range;
            if (!out_of_range && count_q != 32'hFFFF_FFFF) begin
                count_d = count_q + 32'd1;
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pc_q    <= {RESET_PC[31:2], 2'b00};
            instr_q <= 32'h0;
            pcp4_q  <= 32'h0;
            valid_q <= 1'b0;
            count_q <= 32'h0;
            fault_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pcp4_q  <= pcp4_d;
            valid_q <= valid_d;
            count_q <= count_d;
            fault_q <= fault_d;
        end
    end

    assign PC               = pc_q;
    assign IFID_Instruction = instr_q;
    assign IFID_PCPlus4     = pcp4_q;
    assign IFID_Valid       = valid_q;
    assign FetchCount       = count_q;
    assign FetchFault       = fault_q;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - scoreboard bench for instruction_fetch_unit with random and directed stimulus
module tb_instruction_fetch_unit;
    localparam int DEPTH = 397;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Stall = 1'b0, BranchTaken = 1'b0, Jump = 1'b0;
    logic [31:0] BranchTarget = 32'h0, JumpTarget = 32'h0;
    logic [31:0] PC, IFID_Instruction, IFID_PCPlus4, FetchCount;
    logic        IFID_Valid, FetchFault;

    logic [31:0] mem [0:1023];
    instruction_fetch_unit_if ifc ();
    assign ifc.IMemInstruction = mem[ifc.IMemAddress];

    instruction_fetch_unit #(.RESET_PC(32'h0), .IMEM_DEPTH(DEPTH)) dut (
        .Clk(Clk), .Reset(Reset), .Stall(Stall), .BranchTaken(BranchTaken),
        .BranchTarget(BranchTarget), .Jump(Jump), .JumpTarget(JumpTarget),
        .imem(ifc), .PC(PC), .IFID_Instruction(IFID_Instruction),
        .IFID_PCPlus4(IFID_PCPlus4), .IFID_Valid(IFID_Valid),
        .FetchCount(FetchCount), .FetchFault(FetchFault)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] p4;
        logic        valid;
        logic [31:0] count;
        logic        fault;
    } exp_t;

    exp_t exp_q[$];
    exp_t m;
    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", name, act, expv);
        end
    endtask

    task automatic model_reset();
        m = '0;
    endtask

    // Reference: what the fetch stage should hold after one edge with these controls.
    task automatic cycle(input logic st, input logic br, input logic [31:0] bt,
                         input logic jp, input logic [31:0] jt);
        logic oob;
        Stall = st; BranchTaken = br; BranchTarget = bt; Jump = jp; JumpTarget = jt;
        if (jp || br) begin
            m.pc    = (jp ? jt : bt) & 32'hFFFF_FFFC;
            m.instr = 0;
            m.p4    = 0;
            m.valid = 0;
        end else if (!st) begin
`ifdef IMEM_BOUND_CHECK_EN
            oob = (int'(m.pc[11:2]) >= DEPTH);
`else
            oob = 1'b0;
`endif
            m.instr = oob ? 32'h0 : mem[m.pc[11:2]];
            m.p4    = m.pc + 32'd4;
            m.valid = !oob;
            if (!oob && m.count != 32'hFFFF_FFFF) m.count = m.count + 1;
            if (oob) m.fault = 1'b1;
            m.pc    = m.pc + 32'd4;
        end
        exp_q.push_back(m);
        @(negedge Clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_pc"}, PC, 32'h0);
        chk({tag, "_instr"}, IFID_Instruction, 32'h0);
        chk({tag, "_p4"}, IFID_PCPlus4, 32'h0);
        chk({tag, "_valid"}, {31'h0, IFID_Valid}, 32'h0);
        chk({tag, "_count"}, FetchCount, 32'h0);
        chk({tag, "_fault"}, {31'h0, FetchFault}, 32'h0);
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset = 1'b1;
        Stall = 0; BranchTaken = 0; Jump = 0;
        model_reset();
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    // Monitor: every edge that has a pending expectation is compared just after it.
    always @(posedge Clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("sb_pc", PC, e.pc);
            chk("sb_instr", IFID_Instruction, e.instr);
            chk("sb_pcplus4", IFID_PCPlus4, e.p4);
            chk("sb_valid", {31'h0, IFID_Valid}, {31'h0, e.valid});
            chk("sb_count", FetchCount, e.count);
            chk("sb_fault", {31'h0, FetchFault}, {31'h0, e.fault});
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = i * 3;
        model_reset();
        #12;
        check_reset_values("reset");
        @(negedge Clk);
        Reset = 1'b0;

        idle(3);
        chk("tp_seq_instr", IFID_Instruction, 32'd6);
        chk("tp_seq_p4", IFID_PCPlus4, 32'd12);
        chk("tp_seq_count", FetchCount, 32'd3);

        idle(1);
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("tp_stall_pc", PC, 32'h10);
        idle(1);
        chk("tp_stall_instr", IFID_Instruction, 32'd12);
        chk("tp_stall_pc_after", PC, 32'h14);

        for (int i = 0; i < 20 && m.pc != 32'h20; i++) idle(1);
        chk("tp_branch_at", PC, 32'h20);
        cycle(1'b0, 1'b1, 32'h40, 1'b0, 32'h0);
        idle(1);
        chk("tp_branch_instr", IFID_Instruction, 32'd48);
        chk("tp_branch_p4", IFID_PCPlus4, 32'h44);

        cycle(1'b1, 1'b1, 32'h80, 1'b1, 32'h100);
        chk("tp_jump_pc", PC, 32'h100);
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 32'h103);
        chk("tp_jump_align", PC, 32'h100);

        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        for (int i = 0; i < 400; i++) begin
            logic [31:0] bt, jt;
            bt = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'h0000_0FFF);
            jt = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'h0000_0FFF);
            cycle($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, bt,
                  $urandom_range(0, 9) == 0, jt);
        end

        for (int i = 0; i < 1024; i++) mem[i] = i * 3;
        do_reset();
        idle(12);
        chk("async_pre_pc", PC, 32'h30);
        chk("async_pre_valid", {31'h0, IFID_Valid}, 32'h1);
        cycle(1'b1, 1'b1, 32'h200, 1'b0, 32'h0);
        #2;
        Reset = 1'b1;
        #1;
        check_reset_values("async");
        model_reset();
        @(negedge Clk);
        Reset = 1'b0;

        cycle(1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC);
        idle(2);
        chk("wrap_pc", PC, 32'h4);

`ifdef IMEM_BOUND_CHECK_EN
        do_reset();
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 32'h630);
        idle(1);
        chk("bound_last_instr", IFID_Instruction, 32'd1188);
        chk("bound_last_valid", {31'h0, IFID_Valid}, 32'h1);
        idle(1);
        chk("bound_fault", {31'h0, FetchFault}, 32'h1);
        chk("bound_valid", {31'h0, IFID_Valid}, 32'h0);
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 32'h40);
        idle(2);
        chk("bound_sticky", {31'h0, FetchFault}, 32'h1);
`endif

        do_reset();
        check_reset_values("final");
        @(negedge Clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
